// File: rtl/hsv_frame_sequencer.sv
// Frame sequencer: walks one LED frame of HSV words through an external HSV-to-RGB
// converter and streams the registered RGB out. Optional `HSV_SEQ_FRAME_DONE_EN adds frame_done.

module hsv_frame_sequencer #(
  parameter int unsigned NUM_PIXELS = 60,
  parameter int unsigned IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [15:0]      hue_step,
  input  logic [15:0]      frame_hue_inc,
  input  logic [7:0]       sat,
  input  logic [7:0]       val,
  input  logic [23:0]      frame_gap,
  output logic [31:0]      hsv_out,
  input  logic [23:0]      rgb_in,
  output logic [23:0]      pix_data,
  output logic [IDX_W-1:0] pix_index,
  output logic             pix_last,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy
`ifdef HSV_SEQ_FRAME_DONE_EN
  ,
  output logic             frame_done
`endif
);

  localparam int unsigned HUE_W = 11;
  localparam int unsigned GAP_W = 24;
  localparam logic [HUE_W-1:0] HUE_MAX  = HUE_W'(1535);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CONV = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  function automatic logic [HUE_W-1:0] clamp_hue(input logic [15:0] x);
    return (x > 16'(HUE_MAX)) ? HUE_MAX : HUE_W'(x);
  endfunction

  // Both operands are below 1536, so a single conditional subtract keeps the result in range.
  function automatic logic [HUE_W-1:0] wrap_add(input logic [HUE_W-1:0] a,
                                                input logic [HUE_W-1:0] b);
    logic [16:0] sum;
    sum = 17'(a) + 17'(b);
    if (sum >= 17'd1536) sum = sum - 17'd1536;
    return HUE_W'(sum);
  endfunction

  state_t             state_q, state_d;
  logic [HUE_W-1:0]   base_hue_q, base_hue_d;
  logic [HUE_W-1:0]   cur_hue_q, cur_hue_d;
  logic [HUE_W-1:0]   step_s_q, step_s_d;
  logic [HUE_W-1:0]   inc_s_q, inc_s_d;
  logic [7:0]         sat_s_q, sat_s_d;
  logic [7:0]         val_s_q, val_s_d;
  logic [GAP_W-1:0]   gap_s_q, gap_s_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        hsv_q, hsv_d;
  logic [23:0]        pix_data_q, pix_data_d;
  logic [IDX_W-1:0]   pix_index_q, pix_index_d;
  logic               pix_last_q, pix_last_d;
  logic               pix_valid_q, pix_valid_d;
  logic               busy_q, busy_d;
`ifdef HSV_SEQ_FRAME_DONE_EN
  logic               frame_done_q, frame_done_d;
`endif

  logic               last_c;
  logic               handshake_c;
  logic [HUE_W-1:0]   next_hue_c;

  assign last_c      = (idx_q == LAST_IDX);
  assign handshake_c = (state_q == S_SEND) && pix_valid_q && pix_ready;
  assign next_hue_c  = wrap_add(cur_hue_q, step_s_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (enable) state_d = S_LOAD;
      S_LOAD: state_d = S_CONV;
      S_CONV: state_d = S_SEND;
      S_SEND: if (handshake_c) state_d = last_c ? S_GAP : S_CONV;
      S_GAP:  if (gap_cnt_q <= GAP_W'(1)) state_d = enable ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    base_hue_d  = base_hue_q;
    cur_hue_d   = cur_hue_q;
    step_s_d    = step_s_q;
    inc_s_d     = inc_s_q;
    sat_s_d     = sat_s_q;
    val_s_d     = val_s_q;
    gap_s_d     = gap_s_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    hsv_d       = hsv_q;
    pix_data_d  = pix_data_q;
    pix_index_d = pix_index_q;
    pix_last_d  = pix_last_q;
    pix_valid_d = pix_valid_q;
`ifdef HSV_SEQ_FRAME_DONE_EN
    frame_done_d = 1'b0;
`endif
    unique case (state_q)
      S_LOAD: begin
        step_s_d  = clamp_hue(hue_step);
        inc_s_d   = clamp_hue(frame_hue_inc);
        sat_s_d   = sat;
        val_s_d   = val;
        gap_s_d   = frame_gap;
        cur_hue_d = base_hue_q;
        idx_d     = '0;
        hsv_d     = {16'(base_hue_q), sat, val};
      end
      S_CONV: begin
        pix_data_d  = rgb_in;
        pix_index_d = idx_q;
        pix_last_d  = last_c;
        pix_valid_d = 1'b1;
      end
      S_SEND: begin
        if (handshake_c) begin
          pix_valid_d = 1'b0;
          pix_last_d  = 1'b0;
          if (last_c) begin
            base_hue_d = wrap_add(base_hue_q, inc_s_q);
            gap_cnt_d  = (gap_s_q == '0) ? GAP_W'(1) : gap_s_q;
`ifdef HSV_SEQ_FRAME_DONE_EN
            frame_done_d = 1'b1;
`endif
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            cur_hue_d = next_hue_c;
            hsv_d     = {16'(next_hue_c), sat_s_q, val_s_q};
          end
        end
      end
      S_GAP: gap_cnt_d = gap_cnt_q - GAP_W'(1);
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // Datapath registers; a pending pixel is discarded on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_hue_q  <= '0;
      cur_hue_q   <= '0;
      step_s_q    <= '0;
      inc_s_q     <= '0;
      sat_s_q     <= '0;
      val_s_q     <= '0;
      gap_s_q     <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      hsv_q       <= '0;
      pix_data_q  <= '0;
      pix_index_q <= '0;
      pix_last_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef HSV_SEQ_FRAME_DONE_EN
      frame_done_q <= 1'b0;
`endif
    end else begin
      base_hue_q  <= base_hue_d;
      cur_hue_q   <= cur_hue_d;
      step_s_q    <= step_s_d;
      inc_s_q     <= inc_s_d;
      sat_s_q     <= sat_s_d;
      val_s_q     <= val_s_d;
      gap_s_q     <= gap_s_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      hsv_q       <= hsv_d;
      pix_data_q  <= pix_data_d;
      pix_index_q <= pix_index_d;
      pix_last_q  <= pix_last_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
`ifdef HSV_SEQ_FRAME_DONE_EN
      frame_done_q <= frame_done_d;
`endif
    end
  end

  assign hsv_out   = hsv_q;
  assign pix_data  = pix_data_q;
  assign pix_index = pix_index_q;
  assign pix_last  = pix_last_q;
  assign pix_valid = pix_valid_q;
  assign busy      = busy_q;
`ifdef HSV_SEQ_FRAME_DONE_EN
  assign frame_done = frame_done_q;
`endif

endmodule
